tqvp_param_irq_regs: RTL and testbench
======================================

# tqvp_param_irq_regs

Parametrised TinyQV peripheral: a bank of NUM_REGS 32-bit read/write scratch registers with byte-lane writes, plus IRQ_CHANNELS edge-detecting interrupt channels on ui_in with per-channel mode, enable and write-1-to-clear status. It sits in a TinyQV peripheral slot, drives uo_out from register 0 and raises user_interrupt from any enabled pending channel. An optional event counter records qualified edges.

## Interface
- NUM_REGS, 4, number of scratch registers (1..8), at addresses 0x00, 0x04, ... 4*(NUM_REGS-1)
- IRQ_CHANNELS, 8, number of interrupt channels (1..8); channel i watches ui_in[i]
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  input PMOD, already synchronised upstream
- uo_out  out  8  REG0[7:0]
- address  in  6  byte address within peripheral
- data_in  in  32  write data; bottom 8/16/32 bits valid
- data_write_n  in  2  11 none, 00 byte, 01 half, 10 word
- data_read_n  in  2  unused (reads have no side effects)
- data_out  out  32  read data, combinational from address
- data_ready  out  1  constant 1
- user_interrupt  out  1  |(IRQ_STATUS & IRQ_ENABLE)

## Operation
- Address map: REGi at 4*i; 0x20 RAW (read-only, {24'h0, ui_in}); 0x24 IRQ_STATUS (W1C, IRQ_CHANNELS bits); 0x28 IRQ_ENABLE (RW); 0x2C IRQ_MODE (RW, 2 bits per channel, channel i at [2i+1:2i]); 0x30 EVENT_COUNT (see Configuration). Unmapped reads and writes: read 0, write ignored.
- Byte lanes: data_write_n != 11 writes [7:0]; 00→only [7:0]; 01→[15:0]; 10→[31:0]. Same rule for control registers; bits beyond a register's width ignored on write, read as 0.
- IRQ_MODE per channel: 00 off, 01 rising, 10 falling, 11 both edges.
- Edge detect: last_ui register holds ui_in from the previous cycle. event[i] = mode-qualified difference between ui_in[i] and last_ui[i].
- IRQ_STATUS[i] sets on event[i] regardless of IRQ_ENABLE; cleared by writing 1 to bit i at 0x24 (byte write suffices). Writing 0 has no effect.
- Simultaneous event and W1C on the same bit: set wins (bit stays 1).
- Changing IRQ_MODE to 00 does not clear pending status.
- Writes to RAW ignored.

## Timing
- Reset (rst_n low at a clock edge): all REGi, IRQ_STATUS, IRQ_ENABLE, IRQ_MODE, EVENT_COUNT = 0; last_ui loads ui_in (no spurious edge after reset release); uo_out = 0, user_interrupt = 0. data_out during reset reflects reset register values.
- Writes take effect at the edge where data_write_n != 11; readback valid the following cycle.
- Reads: zero-latency, data_ready always 1.
- ui_in[i] first presents a new value before edge k → IRQ_STATUS[i] = 1 after edge k → user_interrupt high after edge k if enabled (combinational from status/enable registers, no extra cycle).
- Setting IRQ_ENABLE[i] while IRQ_STATUS[i] pending asserts user_interrupt in the cycle after the write edge.
- Reset mid-operation overrides any concurrent write or event.

## Configuration
- TQVP_EVENT_COUNT_EN defined: 16-bit EVENT_COUNT at 0x30 increments by 1 on every cycle with at least one event (multiple channels same cycle count once); saturates at 0xFFFF; any write to 0x30 clears it; write and event same cycle → value 1.
- Undefined: no counter logic; 0x30 reads 0, writes ignored.

## Test plan
- Write 0xDEADBEEF word to REG1, then byte 0x55 to REG1 → reads 0xDEADBE55; half 0x1234 → 0xDEAD1234; uo_out unaffected (REG0 = 0).
- Word write 0x000000A5 to REG0 → uo_out = 0xA5 next cycle; read 0x20 with ui_in = 0x3C → 0x0000003C.
- IRQ_MODE ch2 = 01, IRQ_ENABLE = 0x04, ui_in[2] 0→1 → IRQ_STATUS = 0x04, user_interrupt = 1; write 0x04 to 0x24 → both 0; 1→0 transition → no status.
- IRQ_MODE ch0 = 11, enable 0: toggle ui_in[0] twice → status bit 0 set, user_interrupt 0; set enable bit 0 → user_interrupt 1 next cycle; W1C on same cycle as new edge → status stays 1.
- With ui_in = 0xFF held through reset, release reset, IRQ_MODE = 0xFFFF → no status bits set; then ui_in → 0x00 with falling mode → status = 0xFF.
- TQVP_EVENT_COUNT_EN: three separate edges plus one cycle with two simultaneous channel edges → EVENT_COUNT = 4; write to 0x30 → 0; without macro 0x30 reads 0.

Source files
------------

// File: rtl/tqvp_param_irq_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tqvp_param_irq_regs
//  Description : TinyQV peripheral with NUM_REGS 32-bit scratch registers
//                (byte/half/word lane writes) and IRQ_CHANNELS edge-detecting
//                interrupt channels on ui_in.
//                - Per-channel mode: 00 off, 01 rising, 10 falling, 11 both.
//                - Per-channel enable.
//                - Write-1-to-clear status.
//                Optional feature macro TQVP_EVENT_COUNT_EN adds a saturating
//                16-bit event counter at 0x30.
//  Ports       : clk, rst_n (synchronous, active-low)
//                ui_in          input pins watched by the channels
//                uo_out         REG0[7:0]
//                address, data_in, data_write_n, data_read_n : bus
//                data_out       combinational read data
//                data_ready     always 1
//                user_interrupt OR of enabled pending channels
//  Revision    : 1.0  initial release
// ============================================================================
module tqvp_param_irq_regs #(
    parameter int NUM_REGS     = 4,
    parameter int IRQ_CHANNELS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam logic [5:0] c_addr_raw    = 6'h20;
    localparam logic [5:0] c_addr_status = 6'h24;
    localparam logic [5:0] c_addr_enable = 6'h28;
    localparam logic [5:0] c_addr_mode   = 6'h2C;
    localparam int         c_mode_w      = 2 * IRQ_CHANNELS;

    // Reads have no side effects, so the read strobe is not needed.
    logic w_unused;
    assign w_unused = ^data_read_n;

    // ------------------------------------------------------------------
    // Write lane mask
    // ------------------------------------------------------------------
    logic [31:0] w_wmask;
    logic        w_we;

    always_comb begin
        w_wmask = 32'h0;
        case (data_write_n)
            2'b00:   w_wmask = 32'h0000_00FF;
            2'b01:   w_wmask = 32'h0000_FFFF;
            2'b10:   w_wmask = 32'hFFFF_FFFF;
            default: w_wmask = 32'h0;
        endcase
    end

    assign w_we = (data_write_n != 2'b11);

    logic w_wr_status;
    logic w_wr_enable;
    logic w_wr_mode;

    assign w_wr_status = w_we && (address == c_addr_status);
    assign w_wr_enable = w_we && (address == c_addr_enable);
    assign w_wr_mode   = w_we && (address == c_addr_mode);

    // ------------------------------------------------------------------
    // Scratch registers
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0][31:0] regs_q;
    logic [NUM_REGS-1:0][31:0] regs_d;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
            localparam logic [5:0] c_addr = 6'(4 * i);
            assign regs_d[i] = (w_we && (address == c_addr))
                             ? ((regs_q[i] & ~w_wmask) | (data_in & w_wmask))
                             : regs_q[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt channels
    // ------------------------------------------------------------------
    logic [IRQ_CHANNELS-1:0] last_ui_q;
    logic [IRQ_CHANNELS-1:0] status_q, status_d;
    logic [IRQ_CHANNELS-1:0] enable_q, enable_d;
    logic [c_mode_w-1:0]     mode_q, mode_d;
    logic [IRQ_CHANNELS-1:0] w_event;
    logic [IRQ_CHANNELS-1:0] w_clr;

    generate
        for (genvar i = 0; i < IRQ_CHANNELS; i++) begin : g_edge
            logic w_rise;
            logic w_fall;
            assign w_rise     = ui_in[i] & ~last_ui_q[i];
            assign w_fall     = ~ui_in[i] & last_ui_q[i];
            assign w_event[i] = (mode_q[2*i] & w_rise) | (mode_q[2*i+1] & w_fall);
        end
    endgenerate

    assign w_clr = w_wr_status ? (data_in[IRQ_CHANNELS-1:0] & w_wmask[IRQ_CHANNELS-1:0])
                               : '0;

    // The event is OR-ed in after the clear so a same-cycle edge wins.
    assign status_d = (status_q & ~w_clr) | w_event;

    assign enable_d = w_wr_enable
                    ? ((enable_q & ~w_wmask[IRQ_CHANNELS-1:0])
                       | (data_in[IRQ_CHANNELS-1:0] & w_wmask[IRQ_CHANNELS-1:0]))
                    : enable_q;

    assign mode_d = w_wr_mode
                  ? ((mode_q & ~w_wmask[c_mode_w-1:0])
                     | (data_in[c_mode_w-1:0] & w_wmask[c_mode_w-1:0]))
                  : mode_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Capture the pins during reset so release never sees an edge.
            last_ui_q <= ui_in[IRQ_CHANNELS-1:0];
            status_q  <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
        end else begin
            last_ui_q <= ui_in[IRQ_CHANNELS-1:0];
            status_q  <= status_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
        end
    end

`ifdef TQVP_EVENT_COUNT_EN
    // ------------------------------------------------------------------
    // Event counter: one count per cycle with any event, saturating.
    // ------------------------------------------------------------------
    localparam logic [5:0] c_addr_count = 6'h30;

    logic [15:0] count_q, count_d;
    logic        w_wr_count;

    assign w_wr_count = w_we && (address == c_addr_count);

    always_comb begin
        count_d = count_q;
        if (w_wr_count) begin
            count_d = (|w_event) ? 16'd1 : 16'd0;
        end else if ((|w_event) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'h0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        data_out = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (address == 6'(4 * i)) begin
                data_out = regs_q[i];
            end
        end
        case (address)
            c_addr_raw:    data_out = {24'h0, ui_in};
            c_addr_status: data_out[IRQ_CHANNELS-1:0] = status_q;
            c_addr_enable: data_out[IRQ_CHANNELS-1:0] = enable_q;
            c_addr_mode:   data_out[c_mode_w-1:0]     = mode_q;
`ifdef TQVP_EVENT_COUNT_EN
            c_addr_count:  data_out = {16'h0, count_q};
`endif
            default: ;
        endcase
    end

    assign uo_out         = regs_q[0][7:0];
    assign data_ready     = 1'b1;
    assign user_interrupt = |(status_q & enable_q);

endmodule
`default_nettype wire

// File: tb/tb_tqvp_param_irq_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tqvp_param_irq_regs
//  Description : Self-checking bench for tqvp_param_irq_regs. Directed
//                scenarios plus randomized traffic compared against a
//                behavioural model of the register map and interrupt rules.
//                Honours TQVP_EVENT_COUNT_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tqvp_param_irq_regs;

    localparam int NUM_REGS     = 4;
    localparam int IRQ_CHANNELS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tqvp_param_irq_regs #(
        .NUM_REGS     (NUM_REGS),
        .IRQ_CHANNELS (IRQ_CHANNELS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_regs [NUM_REGS];
    logic [7:0]  m_status;
    logic [7:0]  m_enable;
    logic [15:0] m_mode;
    logic [7:0]  m_last;
    int          m_count;

    function automatic logic [31:0] lane_mask(input logic [1:0] wn);
        case (wn)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            2'b10:   return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        logic [7:0]  ev;
        logic [31:0] mask;
        logic [31:0] val;
        bit          clr_count;
        int          idx;
        ev        = 8'h0;
        clr_count = 0;
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
            m_status = 8'h0;
            m_enable = 8'h0;
            m_mode   = 16'h0;
            m_count  = 0;
            m_last   = ui_in;
        end else begin
            for (int ch = 0; ch < IRQ_CHANNELS; ch++) begin
                case (m_mode[2*ch +: 2])
                    2'd1: ev[ch] = (m_last[ch] == 1'b0) && (ui_in[ch] == 1'b1);
                    2'd2: ev[ch] = (m_last[ch] == 1'b1) && (ui_in[ch] == 1'b0);
                    2'd3: ev[ch] = (m_last[ch] != ui_in[ch]);
                    default: ev[ch] = 1'b0;
                endcase
            end
            if (data_write_n != 2'b11) begin
                mask = lane_mask(data_write_n);
                val  = data_in & mask;
                idx  = int'(address) / 4;
                if (address[1:0] == 2'b00 && idx < NUM_REGS) begin
                    m_regs[idx] = (m_regs[idx] & ~mask) | val;
                end else begin
                    case (address)
                        6'h24: m_status = m_status & ~val[7:0];
                        6'h28: m_enable = (m_enable & ~mask[7:0]) | val[7:0];
                        6'h2C: m_mode   = (m_mode & ~mask[15:0]) | val[15:0];
                        6'h30: clr_count = 1;
                        default: ;
                    endcase
                end
            end
            m_status = m_status | ev;
`ifdef TQVP_EVENT_COUNT_EN
            if (clr_count) m_count = 0;
            if (ev != 8'h0 && m_count < 65535) m_count = m_count + 1;
`endif
            m_last = ui_in;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] a);
        int idx;
        idx = int'(a) / 4;
        if (a[1:0] == 2'b00 && idx < NUM_REGS) return m_regs[idx];
        case (a)
            6'h20: return {24'h0, ui_in};
            6'h24: return {24'h0, m_status};
            6'h28: return {24'h0, m_enable};
            6'h2C: return {16'h0, m_mode};
`ifdef TQVP_EVENT_COUNT_EN
            6'h30: return 32'(m_count);
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        tick();
        data_write_n = 2'b11;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        ui_in = 8'h5A;
        tick();
        tick();
        address = 6'h00;
        #1;
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg0_in_reset: got %h want 00000000", data_out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: uo=%h irq=%b rdy=%b want 00/0/1",
                     uo_out, user_interrupt, data_ready);
        end
        for (int a = 0; a <= 6'h30; a += 4) begin
            address = 6'(a);
            #1;
            checks++;
            if (data_out !== ((a == 6'h20) ? 32'h5A : 32'h0)) begin
                errors++;
                $display("FAIL reset_read_%02h: got %h want %h", a, data_out,
                         (a == 6'h20) ? 32'h5A : 32'h0);
            end
        end
    endtask

    task automatic test_regs();
        wr(6'h04, 32'hDEAD_BEEF, 2'b10);
        wr(6'h04, 32'hFFFF_FF55, 2'b00);
        address = 6'h04;
        #1;
        checks++;
        if (data_out !== 32'hDEAD_BE55) begin
            errors++;
            $display("FAIL reg1_byte: got %h want deadbe55", data_out);
        end
        wr(6'h04, 32'hAAAA_1234, 2'b01);
        address = 6'h04;
        #1;
        checks++;
        if (data_out !== 32'hDEAD_1234) begin
            errors++;
            $display("FAIL reg1_half: got %h want dead1234", data_out);
        end
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reg1_uo_untouched: got %h want 00", uo_out);
        end
    endtask

    task automatic test_raw_uo();
        wr(6'h00, 32'h0000_00A5, 2'b10);
        checks++;
        if (uo_out !== 8'hA5) begin
            errors++;
            $display("FAIL uo_out_reg0: got %h want a5", uo_out);
        end
        ui_in = 8'h3C;
        wr(6'h20, 32'hFFFF_FFFF, 2'b10);
        address = 6'h20;
        #1;
        checks++;
        if (data_out !== 32'h0000_003C) begin
            errors++;
            $display("FAIL raw_read: got %h want 0000003c", data_out);
        end
    endtask

    task automatic test_irq_rise();
        ui_in = 8'h00;
        tick();
        wr(6'h2C, 32'h0000_0010, 2'b10);
        wr(6'h28, 32'h0000_0004, 2'b10);
        ui_in = 8'h04;
        tick();
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h4 || user_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL rise_set: status=%h irq=%b want 4/1", data_out, user_interrupt);
        end
        wr(6'h24, 32'h0000_0004, 2'b00);
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h0 || user_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL rise_w1c: status=%h irq=%b want 0/0", data_out, user_interrupt);
        end
        ui_in = 8'h00;
        tick();
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL rise_ignores_fall: status=%h want 0", data_out);
        end
    endtask

    task automatic test_irq_both();
        wr(6'h28, 32'h0, 2'b10);
        wr(6'h2C, 32'h3, 2'b10);
        ui_in = 8'h01;
        tick();
        ui_in = 8'h00;
        tick();
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h1 || user_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL both_pending_disabled: status=%h irq=%b want 1/0",
                     data_out, user_interrupt);
        end
        wr(6'h28, 32'h1, 2'b00);
        checks++;
        if (user_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL enable_late: irq=%b want 1", user_interrupt);
        end
        ui_in = 8'h01;
        wr(6'h24, 32'h1, 2'b00);
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h1) begin
            errors++;
            $display("FAIL set_beats_clear: status=%h want 1", data_out);
        end
        wr(6'h24, 32'h1, 2'b00);
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h0 || user_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL both_clear: status=%h irq=%b want 0/0", data_out, user_interrupt);
        end
    endtask

    task automatic test_reset_held_high();
        ui_in = 8'hFF;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wr(6'h2C, 32'h0000_FFFF, 2'b01);
        tick();
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL no_edge_after_reset: status=%h want 0", data_out);
        end
        ui_in = 8'h00;
        tick();
        address = 6'h24;
        #1;
        checks++;
        if (data_out !== 32'hFF || user_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL all_falling: status=%h irq=%b want ff/0", data_out, user_interrupt);
        end
    endtask

    task automatic test_event_count();
`ifdef TQVP_EVENT_COUNT_EN
        wr(6'h30, 32'h0, 2'b10);
        ui_in = 8'h01; tick();
        ui_in = 8'h03; tick();
        ui_in = 8'h02; tick();
        tick();
        ui_in = 8'h0E; tick();
        address = 6'h30;
        #1;
        checks++;
        if (data_out !== 32'd4) begin
            errors++;
            $display("FAIL count_four: got %0d want 4", data_out);
        end
        wr(6'h30, 32'h0, 2'b00);
        address = 6'h30;
        #1;
        checks++;
        if (data_out !== 32'd0) begin
            errors++;
            $display("FAIL count_clear: got %0d want 0", data_out);
        end
        ui_in = 8'h0F;
        wr(6'h30, 32'h0, 2'b10);
        address = 6'h30;
        #1;
        checks++;
        if (data_out !== 32'd1) begin
            errors++;
            $display("FAIL count_clear_with_event: got %0d want 1", data_out);
        end
`else
        ui_in = 8'h05;
        wr(6'h30, 32'hFFFF_FFFF, 2'b10);
        address = 6'h30;
        #1;
        checks++;
        if (data_out !== 32'd0) begin
            errors++;
            $display("FAIL count_absent: got %h want 0", data_out);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] addrs [10];
        logic [5:0] ra;
        logic [31:0] exp;
        addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h20, 6'h24, 6'h28, 6'h2C, 6'h30, 6'h34};
        for (int n = 0; n < 400; n++) begin
            // Hold pins steady most of the time so edges stay meaningful.
            if ($urandom_range(0, 2) == 0) ui_in = 8'($urandom);
            rst_n        = ($urandom_range(0, 49) != 0);
            address      = addrs[$urandom_range(0, 9)];
            data_in      = $urandom;
            data_write_n = 2'($urandom_range(0, 3));
            tick();
            rst_n        = 1'b1;
            data_write_n = 2'b11;
            checks++;
            if (uo_out !== m_regs[0][7:0] || user_interrupt !== |(m_status & m_enable)) begin
                errors++;
                $display("FAIL rand_outputs[%0d]: uo=%h irq=%b want %h/%b", n, uo_out,
                         user_interrupt, m_regs[0][7:0], |(m_status & m_enable));
            end
            ra      = addrs[$urandom_range(0, 9)];
            address = ra;
            #1;
            exp = exp_read(ra);
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL rand_read[%0d] addr %h: got %h want %h", n, ra, data_out, exp);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ui_in        = 8'h00;
        address      = 6'h00;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
        m_status = 8'h0;
        m_enable = 8'h0;
        m_mode   = 16'h0;
        m_last   = 8'h0;
        m_count  = 0;

        test_reset();
        test_regs();
        test_raw_uo();
        test_irq_rise();
        test_irq_both();
        test_reset_held_high();
        test_event_count();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
